// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: field widths,
// the reserved destination address and the transmit FSM encoding.
package router_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUF_DEPTH = 63;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity
    } state_e;

    // Header byte layout: payload length in the upper bits, destination below.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Source/router side signals of the packet transmitter.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0]  payload_len;
    logic [DATA_W-1:0] pl_data;
    logic              pl_valid;
    logic              pl_ready;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              pkt_valid;
    logic              tx_active;
    logic              done;
    logic              req_err;

    // Environment side: requests packets, supplies payload, applies router stall.
    modport master (
        output start, dest_addr, payload_len, pl_data, pl_valid, busy,
        input  pl_ready, data_out, pkt_valid, tx_active, done, req_err
    );

    // Transmitter side.
    modport slave (
        input  start, dest_addr, payload_len, pl_data, pl_valid, busy,
        output pl_ready, data_out, pkt_valid, tx_active, done, req_err
    );

endinterface

// File: rtl/router_tx_buf.sv
// 63x8 payload store with independent write and read pointers.
// Read data is combinational from the current read pointer.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;

    // Pointer advance; clear wins over any access in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i) wr_ptr_d = wr_ptr_q + LEN_W'(1);
            if (rd_en_i) rd_ptr_d = rd_ptr_q + LEN_W'(1);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers gate every use.
    always_ff @(posedge clock) begin
        if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header,
// payload bytes and an XOR parity byte, stalling whenever the router is busy.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic           clock,
    input  logic           rst,
    router_pkt_tx_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              done_q, done_d;
    logic              req_err_q, req_err_d;

    logic              buf_wr, buf_rd, buf_clr;
    logic [DATA_W-1:0] buf_rd_data;
    logic              start_ok;
    logic              last_cnt;

    assign start_ok = (bus.payload_len != '0) && (bus.dest_addr != INVALID_ADDR);
    assign last_cnt = (cnt_q == len_q - LEN_W'(1));

    // Next-state, datapath and buffer control; outputs hold unless consumed.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        parity_d    = parity_q;
        pkt_valid_d = pkt_valid_q;
        done_d      = 1'b0;
        req_err_d   = 1'b0;
        buf_wr      = 1'b0;
        buf_rd      = 1'b0;
        buf_clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (start_ok) begin
                        addr_d   = bus.dest_addr;
                        len_d    = bus.payload_len;
                        cnt_d    = '0;
                        parity_d = '0;
                        buf_clr  = 1'b1;
                        state_d  = StLoad;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (bus.pl_valid) begin
                    buf_wr   = 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    cnt_d    = cnt_q + LEN_W'(1);
                    if (last_cnt) begin
                        data_out_d  = make_header(len_q, addr_q);
                        pkt_valid_d = 1'b1;
                        parity_d    = parity_q ^ bus.pl_data ^ make_header(len_q, addr_q);
                        cnt_d       = '0;
                        state_d     = StHeader;
                    end
                end
            end
            StHeader: begin
                if (!bus.busy) begin
                    data_out_d = buf_rd_data;
                    buf_rd     = 1'b1;
                    state_d    = StPayload;
                end
            end
            StPayload: begin
                if (!bus.busy) begin
                    if (last_cnt) begin
                        data_out_d  = parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = StParity;
                    end else begin
                        data_out_d = buf_rd_data;
                        buf_rd     = 1'b1;
                        cnt_d      = cnt_q + LEN_W'(1);
                    end
                end
            end
            StParity: begin
                if (!bus.busy) begin
                    data_out_d = '0;
                    parity_d   = '0;
                    cnt_d      = '0;
                    buf_clr    = 1'b1;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            parity_q    <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            parity_q    <= parity_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
        end
    end

    router_tx_buf u_buf (
        .clock     (clock),
        .rst       (rst),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wr_data_i (bus.pl_data),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_rd_data)
    );

    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.done      = done_q;
    assign bus.req_err   = req_err_q;
    assign bus.pl_ready  = (state_q == StLoad);
    assign bus.tx_active = (state_q != StIdle);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: every beat the router consumes is
// recorded and compared against hand-computed packet streams.
module tb_router_pkt_tx;
    import router_pkg::*;

    logic clock = 1'b0;
    logic rst;

    router_pkt_tx_if bus ();

    router_pkt_tx dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] got_q[$];  // {pkt_valid, data_out} of each consumed beat
    int         beats02;
    bit         saw_valid;
    bit         found;
    logic [7:0] pl[$];
    logic [7:0] par;

    // Beats consumed by the router: presented outside LOAD while not stalled.
    always @(negedge clock) begin
        if (!rst && bus.tx_active && !bus.pl_ready && !bus.busy)
            got_q.push_back({bus.pkt_valid, bus.data_out});
        if (bus.pkt_valid) saw_valid = 1'b1;
        if (bus.pkt_valid && bus.data_out == 8'h02) beats02++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
        bus.start       = 1'b1;
        bus.dest_addr   = a;
        bus.payload_len = l;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            bus.pl_valid = 1'b0;
            tick();
        end
        bus.pl_valid = 1'b1;
        bus.pl_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.pl_ready;
            tick();
        end
        bus.pl_valid = 1'b0;
        if (!ok) check_eq("feed_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = bus.done;
        end
        check_eq({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_idle"}, 32'(bus.tx_active), 32'd0);
            tick();
            check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    task automatic wait_byte(input logic [7:0] b);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.pkt_valid && bus.data_out == b) found = 1'b1;
            else tick();
        end
        check_eq("wait_byte", 32'(found), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] hdr,
                                input logic [7:0] exp_pl[$], input logic [7:0] exp_par);
        check_eq({tag, "_beats"}, 32'(got_q.size()), 32'(exp_pl.size() + 2));
        if (got_q.size() == exp_pl.size() + 2) begin
            check_eq({tag, "_hdr"}, 32'(got_q[0]), 32'({1'b1, hdr}));
            foreach (exp_pl[i])
                check_eq($sformatf("%s_pl%0d", tag, i), 32'(got_q[i+1]), 32'({1'b1, exp_pl[i]}));
            check_eq({tag, "_par"}, 32'(got_q[exp_pl.size()+1]), 32'({1'b0, exp_par}));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data_out"},  32'(bus.data_out),  32'd0);
        check_eq({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
        check_eq({tag, "_pl_ready"},  32'(bus.pl_ready),  32'd0);
        check_eq({tag, "_tx_active"}, 32'(bus.tx_active), 32'd0);
        check_eq({tag, "_done"},      32'(bus.done),      32'd0);
        check_eq({tag, "_req_err"},   32'(bus.req_err),   32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.dest_addr   = '0;
        bus.payload_len = '0;
        bus.pl_data     = '0;
        bus.pl_valid    = 1'b0;
        bus.busy        = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic packet: addr 2, len 5, payload 01..05.
        got_q.delete();
        start_pkt(2'd2, 6'd5);
        check_eq("load_pl_ready", 32'(bus.pl_ready), 32'd1);
        check_eq("load_tx_active", 32'(bus.tx_active), 32'd1);
        for (int i = 1; i <= 5; i++) feed(8'(i), 1'b0);
        check_eq("hdr_after_load", 32'(bus.data_out), 32'h16);
        check_eq("hdr_valid", 32'(bus.pkt_valid), 32'd1);
        wait_done("basic");
        pl.delete();
        for (int i = 1; i <= 5; i++) pl.push_back(8'(i));
        check_stream("basic", 8'h16, pl, 8'h17);

        // Rejected starts: zero length, then reserved address.
        saw_valid = 1'b0;
        start_pkt(2'd1, 6'd0);
        check_eq("rej_len_err", 32'(bus.req_err), 32'd1);
        check_eq("rej_len_active", 32'(bus.tx_active), 32'd0);
        tick();
        check_eq("rej_len_pulse", 32'(bus.req_err), 32'd0);
        start_pkt(2'd3, 6'd4);
        check_eq("rej_addr_err", 32'(bus.req_err), 32'd1);
        check_eq("rej_addr_active", 32'(bus.tx_active), 32'd0);
        tick();
        check_eq("rej_addr_pulse", 32'(bus.req_err), 32'd0);
        repeat (3) tick();
        check_eq("rej_no_valid", 32'(saw_valid), 32'd0);
        check_eq("rej_idle", 32'(bus.tx_active), 32'd0);

        // Router stall while byte 02 is presented.
        got_q.delete();
        start_pkt(2'd2, 6'd5);
        for (int i = 1; i <= 5; i++) feed(8'(i), 1'b0);
        beats02 = 0;
        wait_byte(8'h02);
        bus.busy = 1'b1;
        repeat (3) tick();
        check_eq("busy_hold_data", 32'(bus.data_out), 32'h02);
        check_eq("busy_hold_valid", 32'(bus.pkt_valid), 32'd1);
        bus.busy = 1'b0;
        wait_done("busy");
        check_eq("busy_02_cycles", 32'(beats02), 32'd4);
        check_stream("busy", 8'h16, pl, 8'h17);

        // Start during payload is ignored.
        got_q.delete();
        start_pkt(2'd2, 6'd5);
        for (int i = 1; i <= 5; i++) feed(8'(i), 1'b0);
        wait_byte(8'h01);
        start_pkt(2'd1, 6'd9);
        check_eq("midstart_no_err", 32'(bus.req_err), 32'd0);
        wait_done("midstart");
        check_stream("midstart", 8'h16, pl, 8'h17);

        // Full-depth packet with pl_valid toggling.
        got_q.delete();
        start_pkt(2'd0, 6'd63);
        pl.delete();
        par = 8'hFC;
        for (int i = 0; i < 63; i++) begin
            feed(8'(i), 1'b1);
            pl.push_back(8'(i));
            par = par ^ 8'(i);
        end
        wait_done("long");
        check_stream("long", 8'hFC, pl, par);

        // Reset mid-payload, then a fresh one-byte packet.
        got_q.delete();
        start_pkt(2'd2, 6'd5);
        for (int i = 1; i <= 5; i++) feed(8'(i), 1'b0);
        wait_byte(8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        tick();
        got_q.delete();
        start_pkt(2'd1, 6'd1);
        feed(8'hAA, 1'b0);
        wait_done("after_rst");
        pl.delete();
        pl.push_back(8'hAA);
        check_stream("after_rst", 8'h05, pl, 8'hAF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
